// File: rtl/voice_scheduler.sv
// voice_scheduler
// Sequencing controller for the synth voice datapath. Each SAMPLE_REQ clears
// the shared tone accumulator, walks every key, and runs one accumulate step
// per active voice. The mixed 32-bit sample is then latched on SAMPLE_OUT.
// The block also owns the per-key note lifecycle bitmaps (gate, active,
// restart), which are driven by NIOS Avalon note writes and by NOTE_END from
// the envelope.
//
// Optional feature: define VOICE_LIMIT_EN to cap polyphony at MAX_VOICES.
// With the cap enabled, a note-on to an inactive key is dropped while the
// cap is reached. Retriggers of an already active key are still accepted.
//
// Ports:
//   CLK, RESET (async, active-low)
//   SAMPLE_REQ              codec sample request pulse
//   AVL_WRITE/KEY/VEL       NIOS note write (VEL == 0 is note-off)
//   NOTE_END                release envelope finished (honoured in UPDATE only)
//   TONE                    datapath accumulator value
//   KEY                     datapath key address
//   LD_PHASE/COUNT/TONE/VEL datapath load strobes
//   PHASE_MUX/COUNTER_MUX   0 = restart the voice, 1 = continue the voice
//   TONE_MUX                0 = clear the accumulator, 1 = accumulate
//   NOTE_ON                 gate bit of the current KEY
//   SAMPLE_OUT/SAMPLE_VALID latched mix and its one-cycle update pulse
//   BUSY, OVERRUN           scan in progress / sticky dropped request
//   ACTIVE_CNT              popcount of the active bitmap
module voice_scheduler #(
  parameter int NUM_KEYS      = 128,
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_VOICES    = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SAMPLE_REQ,
  input  logic        AVL_WRITE,
  input  logic [6:0]  AVL_KEY,
  input  logic [6:0]  AVL_VEL,
  input  logic        NOTE_END,
  input  logic [31:0] TONE,
  output logic [6:0]  KEY,
  output logic        LD_PHASE,
  output logic        LD_COUNT,
  output logic        LD_TONE,
  output logic        LD_VEL,
  output logic        PHASE_MUX,
  output logic        COUNTER_MUX,
  output logic        TONE_MUX,
  output logic        NOTE_ON,
  output logic [31:0] SAMPLE_OUT,
  output logic        SAMPLE_VALID,
  output logic        BUSY,
  output logic        OVERRUN,
  output logic [7:0]  ACTIVE_CNT
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_SCAN   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_UPDATE = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [6:0] LP_LAST        = 7'(NUM_KEYS - 1);
  localparam logic [1:0] LP_SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 4 || MAX_VOICES < 1 || MAX_VOICES > NUM_KEYS) begin : g_param_check
    $error("voice_scheduler: illegal parameter value");
  end

  logic [2:0]          r_state, w_state_nx;
  logic [6:0]          r_idx, w_idx_nx;
  logic [1:0]          r_settle, w_settle_nx;
  logic [NUM_KEYS-1:0] r_gate, r_active, r_restart;
  logic [NUM_KEYS-1:0] w_gate_nx, w_active_nx, w_restart_nx;
  logic [31:0]         r_sample_out;
  logic                r_sample_valid;
  logic                r_overrun;
  logic [7:0]          r_active_cnt;
  logic                w_update, w_clear, w_busy, w_last, w_note_on, w_accept;

  function automatic logic [7:0] f_popcount(input logic [NUM_KEYS-1:0] v);
    logic [7:0] cnt;
    cnt = 8'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt = cnt + {7'd0, v[i]};
    end
    return cnt;
  endfunction

  assign w_update  = (r_state == ST_UPDATE);
  assign w_clear   = (r_state == ST_CLEAR);
  assign w_busy    = (r_state != ST_IDLE);
  assign w_last    = (r_idx == LP_LAST);
  assign w_note_on = (AVL_VEL != 7'd0);

`ifdef VOICE_LIMIT_EN
  // A new voice is refused at the cap; retriggering a sounding key is always allowed.
  assign w_accept = r_active[AVL_KEY] || (r_active_cnt != 8'(MAX_VOICES));
`else
  assign w_accept = 1'b1;
`endif

  assign KEY          = r_idx;
  assign LD_PHASE     = w_update;
  assign LD_COUNT     = w_update;
  assign LD_TONE      = w_update | w_clear;
  assign TONE_MUX     = w_update;
  assign PHASE_MUX    = w_update & ~r_restart[r_idx];
  assign COUNTER_MUX  = w_update & ~r_restart[r_idx];
  assign NOTE_ON      = r_gate[r_idx];
  assign LD_VEL       = AVL_WRITE & w_note_on & w_accept;
  assign BUSY         = w_busy;
  assign SAMPLE_OUT   = r_sample_out;
  assign SAMPLE_VALID = r_sample_valid;
  assign OVERRUN      = r_overrun;
  assign ACTIVE_CNT   = r_active_cnt;

  // Scan sequencer: next state, key pointer and settle counter.
  always_comb begin
    w_state_nx  = r_state;
    w_idx_nx    = r_idx;
    w_settle_nx = r_settle;
    case (r_state)
      ST_IDLE: begin
        if (SAMPLE_REQ) begin
          w_state_nx = ST_CLEAR;
          w_idx_nx   = 7'd0;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        w_state_nx = ST_SCAN;
        w_idx_nx   = 7'd0;
      end
      ST_SCAN: begin
        if (r_active[r_idx]) begin
          // The SCAN cycle already counts as the first settle cycle.
          if (SETTLE_CYCLES == 1) begin
            w_state_nx = ST_UPDATE;
          end else begin
            w_state_nx  = ST_SETTLE;
            w_settle_nx = 2'd1;
          end
        end else if (w_last) begin
          w_state_nx = ST_DONE;
        end else begin
          w_idx_nx = r_idx + 7'd1;
        end
      end
      ST_SETTLE: begin
        if (r_settle == LP_SETTLE_LAST) begin
          w_state_nx = ST_UPDATE;
        end else begin
          w_settle_nx = r_settle + 2'd1;
        end
      end
      ST_UPDATE: begin
        if (w_last) begin
          w_state_nx = ST_DONE;
        end else begin
          w_state_nx = ST_SCAN;
          w_idx_nx   = r_idx + 7'd1;
        end
      end
      ST_DONE: begin
        w_state_nx = ST_IDLE;
        w_idx_nx   = 7'd0;
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_idx_nx   = 7'd0;
      end
    endcase
  end

  // Note bitmaps: the UPDATE step is applied first, so that a same-cycle
  // NIOS write to the same key takes precedence over it.
  always_comb begin
    w_gate_nx    = r_gate;
    w_active_nx  = r_active;
    w_restart_nx = r_restart;
    if (w_update) begin
      w_restart_nx[r_idx] = 1'b0;
      if (NOTE_END && !r_gate[r_idx]) begin
        w_active_nx[r_idx] = 1'b0;
      end else begin
        w_active_nx[r_idx] = r_active[r_idx];
      end
    end else begin
      w_restart_nx = r_restart;
    end
    if (AVL_WRITE) begin
      if (w_note_on) begin
        if (w_accept) begin
          w_gate_nx[AVL_KEY]    = 1'b1;
          w_active_nx[AVL_KEY]  = 1'b1;
          w_restart_nx[AVL_KEY] = 1'b1;
        end else begin
          w_gate_nx[AVL_KEY] = r_gate[AVL_KEY];
        end
      end else begin
        // A note-off only drops the gate. Active and restart keep their
        // pre-write values, which also cancels any UPDATE change to this key.
        w_gate_nx[AVL_KEY]    = 1'b0;
        w_active_nx[AVL_KEY]  = r_active[AVL_KEY];
        w_restart_nx[AVL_KEY] = r_restart[AVL_KEY];
      end
    end else begin
      w_gate_nx = w_gate_nx;
    end
  end

  // State, bitmaps and registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state        <= ST_IDLE;
      r_idx          <= 7'd0;
      r_settle       <= 2'd0;
      r_gate         <= {NUM_KEYS{1'b0}};
      r_active       <= {NUM_KEYS{1'b0}};
      r_restart      <= {NUM_KEYS{1'b0}};
      r_sample_out   <= 32'd0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
      r_active_cnt   <= 8'd0;
    end else begin
      r_state        <= w_state_nx;
      r_idx          <= w_idx_nx;
      r_settle       <= w_settle_nx;
      r_gate         <= w_gate_nx;
      r_active       <= w_active_nx;
      r_restart      <= w_restart_nx;
      r_sample_valid <= (r_state == ST_DONE);
      r_overrun      <= r_overrun | (SAMPLE_REQ & w_busy);
      r_active_cnt   <= f_popcount(r_active);
      if (r_state == ST_DONE) begin
        r_sample_out <= TONE;
      end else begin
        r_sample_out <= r_sample_out;
      end
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
module tb_voice_scheduler;

  logic        CLK = 1'b0;
  logic        RESET, SAMPLE_REQ, AVL_WRITE, NOTE_END;
  logic [6:0]  AVL_KEY, AVL_VEL;
  logic [31:0] tone1 = 32'd0;
  logic [31:0] tone2 = 32'd0;

  logic [6:0]  key1, key2;
  logic        ldp1, ldc1, ldt1, ldv1, pm1, cm1, tm1, non1, sv1, busy1, ovr1;
  logic        ldp2, ldc2, ldt2, ldv2, pm2, cm2, tm2, non2, sv2, busy2, ovr2;
  logic [31:0] so1, so2;
  logic [7:0]  ac1, ac2;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  voice_scheduler u_dut1 (
    .CLK(CLK), .RESET(RESET), .SAMPLE_REQ(SAMPLE_REQ), .AVL_WRITE(AVL_WRITE),
    .AVL_KEY(AVL_KEY), .AVL_VEL(AVL_VEL), .NOTE_END(NOTE_END), .TONE(tone1),
    .KEY(key1), .LD_PHASE(ldp1), .LD_COUNT(ldc1), .LD_TONE(ldt1), .LD_VEL(ldv1),
    .PHASE_MUX(pm1), .COUNTER_MUX(cm1), .TONE_MUX(tm1), .NOTE_ON(non1),
    .SAMPLE_OUT(so1), .SAMPLE_VALID(sv1), .BUSY(busy1), .OVERRUN(ovr1), .ACTIVE_CNT(ac1));

  voice_scheduler #(.SETTLE_CYCLES(2)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .SAMPLE_REQ(SAMPLE_REQ), .AVL_WRITE(AVL_WRITE),
    .AVL_KEY(AVL_KEY), .AVL_VEL(AVL_VEL), .NOTE_END(NOTE_END), .TONE(tone2),
    .KEY(key2), .LD_PHASE(ldp2), .LD_COUNT(ldc2), .LD_TONE(ldt2), .LD_VEL(ldv2),
    .PHASE_MUX(pm2), .COUNTER_MUX(cm2), .TONE_MUX(tm2), .NOTE_ON(non2),
    .SAMPLE_OUT(so2), .SAMPLE_VALID(sv2), .BUSY(busy2), .OVERRUN(ovr2), .ACTIVE_CNT(ac2));

`ifdef VOICE_LIMIT_EN
  logic [6:0]  key3;
  logic        ldp3, ldc3, ldt3, ldv3, pm3, cm3, tm3, non3, sv3, busy3, ovr3;
  logic [31:0] so3;
  logic [7:0]  ac3;
  voice_scheduler #(.MAX_VOICES(2)) u_dut3 (
    .CLK(CLK), .RESET(RESET), .SAMPLE_REQ(SAMPLE_REQ), .AVL_WRITE(AVL_WRITE),
    .AVL_KEY(AVL_KEY), .AVL_VEL(AVL_VEL), .NOTE_END(NOTE_END), .TONE(32'd0),
    .KEY(key3), .LD_PHASE(ldp3), .LD_COUNT(ldc3), .LD_TONE(ldt3), .LD_VEL(ldv3),
    .PHASE_MUX(pm3), .COUNTER_MUX(cm3), .TONE_MUX(tm3), .NOTE_ON(non3),
    .SAMPLE_OUT(so3), .SAMPLE_VALID(sv3), .BUSY(busy3), .OVERRUN(ovr3), .ACTIVE_CNT(ac3));
`endif

  // Datapath stand-in: each accumulate step adds KEY+1 to the tone.
  always @(posedge CLK) begin
    if (ldt1) tone1 <= tm1 ? tone1 + 32'(key1) + 32'd1 : 32'd0;
    if (ldt2) tone2 <= tm2 ? tone2 + 32'(key2) + 32'd1 : 32'd0;
  end

  typedef struct packed {
    bit          is_sample;
    logic [6:0]  key;
    logic [6:0]  vel;
    bit          note_end;
    bit          exp_ldvel;
    logic [7:0]  exp_cnt;
    int          exp_lat1;
    int          exp_lat2;
    logic [31:0] exp_out;
    int          exp_nupd;
    logic [20:0] exp_keys;   // {third, second, first} UPDATE key
    logic [2:0]  exp_pmux;   // bit i = PHASE_MUX of i-th UPDATE
  } vec_t;

  vec_t vecs[15];

  // results of the most recent sample
  int          r_lat1, r_lat2, r_n1, r_n2;
  logic [31:0] r_out1, r_out2;
  logic [6:0]  r_k1[3];
  logic [6:0]  r_k2[3];
  logic [2:0]  r_pm, r_cm;
  logic        r_ldv1, r_ldv3;

  function automatic vec_t mk_wr(input logic [6:0] k, input logic [6:0] v,
                                 input bit ld, input logic [7:0] cnt);
    vec_t r;
    r = '0;
    r.key = k; r.vel = v; r.exp_ldvel = ld; r.exp_cnt = cnt;
    return r;
  endfunction

  function automatic vec_t mk_smp(input bit ne, input int l1, input int l2,
                                  input logic [31:0] o, input int n,
                                  input logic [6:0] k0, input logic [6:0] k1,
                                  input logic [6:0] k2, input logic [2:0] pm,
                                  input logic [7:0] cnt);
    vec_t r;
    r = '0;
    r.is_sample = 1'b1; r.note_end = ne; r.exp_lat1 = l1; r.exp_lat2 = l2;
    r.exp_out = o; r.exp_nupd = n; r.exp_keys = {k2, k1, k0};
    r.exp_pmux = pm; r.exp_cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [6:0] k, input logic [6:0] v);
    @(negedge CLK);
    AVL_WRITE = 1'b1; AVL_KEY = k; AVL_VEL = v;
    #1;
    r_ldv1 = ldv1;
`ifdef VOICE_LIMIT_EN
    r_ldv3 = ldv3;
`else
    r_ldv3 = 1'b0;
`endif
    @(negedge CLK);
    AVL_WRITE = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic run_sample(input bit ne);
    @(negedge CLK);
    SAMPLE_REQ = 1'b1; NOTE_END = ne;
    @(negedge CLK);
    SAMPLE_REQ = 1'b0;
    r_lat1 = -1; r_lat2 = -1; r_n1 = 0; r_n2 = 0; r_pm = 3'd0; r_cm = 3'd0;
    r_out1 = 32'd0; r_out2 = 32'd0;
    for (int j = 0; j < 3; j++) begin r_k1[j] = 7'd0; r_k2[j] = 7'd0; end
    for (int c = 1; c <= 1000 && (r_lat1 < 0 || r_lat2 < 0); c++) begin
      @(negedge CLK);
      if (ldp1) begin
        if (r_n1 < 3) begin r_k1[r_n1] = key1; r_pm[r_n1] = pm1; r_cm[r_n1] = cm1; end
        r_n1++;
      end
      if (ldp2) begin
        if (r_n2 < 3) r_k2[r_n2] = key2;
        r_n2++;
      end
      if (sv1 && r_lat1 < 0) begin r_lat1 = c; r_out1 = so1; end
      if (sv2 && r_lat2 < 0) begin r_lat2 = c; r_out2 = so2; end
    end
    NOTE_END = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    RESET = 1'b0; SAMPLE_REQ = 1'b0; AVL_WRITE = 1'b0; NOTE_END = 1'b0;
    AVL_KEY = 7'd0; AVL_VEL = 7'd0;

    vecs[0]  = mk_smp(1'b0, 130, 130, 32'd0,   0, 7'd0,  7'd0,  7'd0,   3'b000, 8'd0);
    vecs[1]  = mk_wr(7'd60, 7'd100, 1'b1, 8'd1);
    vecs[2]  = mk_smp(1'b0, 131, 132, 32'd61,  1, 7'd60, 7'd0,  7'd0,   3'b000, 8'd1);
    vecs[3]  = mk_smp(1'b0, 131, 132, 32'd61,  1, 7'd60, 7'd0,  7'd0,   3'b001, 8'd1);
    vecs[4]  = mk_wr(7'd60, 7'd0,   1'b0, 8'd1);
    vecs[5]  = mk_wr(7'd61, 7'd1,   1'b1, 8'd2);
    vecs[6]  = mk_smp(1'b1, 132, 134, 32'd123, 2, 7'd60, 7'd61, 7'd0,   3'b001, 8'd1);
    vecs[7]  = mk_wr(7'd61, 7'd0,   1'b0, 8'd1);
    vecs[8]  = mk_smp(1'b1, 131, 132, 32'd62,  1, 7'd61, 7'd0,  7'd0,   3'b001, 8'd0);
    vecs[9]  = mk_wr(7'd0,  7'd5,   1'b1, 8'd1);
    vecs[10] = mk_wr(7'd64, 7'd7,   1'b1, 8'd2);
    vecs[11] = mk_wr(7'd127, 7'd9,  1'b1, 8'd3);
    vecs[12] = mk_smp(1'b0, 133, 136, 32'd194, 3, 7'd0,  7'd64, 7'd127, 3'b000, 8'd3);
    vecs[13] = mk_wr(7'd64, 7'd3,   1'b1, 8'd3);
    vecs[14] = mk_smp(1'b0, 133, 136, 32'd194, 3, 7'd0,  7'd64, 7'd127, 3'b101, 8'd3);

    repeat (3) @(negedge CLK);
    chk("reset busy", 32'(busy1), 32'd0);
    chk("reset valid", 32'(sv1), 32'd0);
    chk("reset overrun", 32'(ovr1), 32'd0);
    chk("reset active_cnt", 32'(ac1), 32'd0);
    chk("reset key", 32'(key1), 32'd0);
    chk("reset sample_out", so1, 32'd0);
    chk("reset ld_tone", 32'(ldt1), 32'd0);
    chk("reset note_on", 32'(non1), 32'd0);
    RESET = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].is_sample) begin
        run_sample(vecs[i].note_end);
        chk($sformatf("v%0d latency", i), 32'(r_lat1), 32'(vecs[i].exp_lat1));
        chk($sformatf("v%0d latency settle2", i), 32'(r_lat2), 32'(vecs[i].exp_lat2));
        chk($sformatf("v%0d sample_out", i), r_out1, vecs[i].exp_out);
        chk($sformatf("v%0d sample_out settle2", i), r_out2, vecs[i].exp_out);
        chk($sformatf("v%0d updates", i), 32'(r_n1), 32'(vecs[i].exp_nupd));
        chk($sformatf("v%0d updates settle2", i), 32'(r_n2), 32'(vecs[i].exp_nupd));
        chk($sformatf("v%0d update keys", i), 32'({r_k1[2], r_k1[1], r_k1[0]}), 32'(vecs[i].exp_keys));
        chk($sformatf("v%0d update keys settle2", i), 32'({r_k2[2], r_k2[1], r_k2[0]}), 32'(vecs[i].exp_keys));
        chk($sformatf("v%0d phase_mux", i), 32'(r_pm), 32'(vecs[i].exp_pmux));
        chk($sformatf("v%0d counter_mux", i), 32'(r_cm), 32'(vecs[i].exp_pmux));
      end else begin
        do_write(vecs[i].key, vecs[i].vel);
        chk($sformatf("v%0d ld_vel", i), 32'(r_ldv1), 32'(vecs[i].exp_ldvel));
      end
      chk($sformatf("v%0d active_cnt", i), 32'(ac1), 32'(vecs[i].exp_cnt));
      chk($sformatf("v%0d active_cnt settle2", i), 32'(ac2), 32'(vecs[i].exp_cnt));
    end

    // Second request 50 cycles into a scan is dropped and flagged.
    @(negedge CLK);
    SAMPLE_REQ = 1'b1;
    @(negedge CLK);
    SAMPLE_REQ = 1'b0;
    nv = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge CLK);
      if (sv1) nv++;
      SAMPLE_REQ = (c == 50);
    end
    chk("overrun valid count", 32'(nv), 32'd1);
    chk("overrun flag", 32'(ovr1), 32'd1);
    chk("overrun flag settle2", 32'(ovr2), 32'd1);

    // Reset in the middle of a scan.
    @(negedge CLK);
    SAMPLE_REQ = 1'b1;
    @(negedge CLK);
    SAMPLE_REQ = 1'b0;
    repeat (20) @(negedge CLK);
    chk("midscan busy before reset", 32'(busy1), 32'd1);
    RESET = 1'b0;
    #1;
    chk("midscan reset busy", 32'(busy1), 32'd0);
    chk("midscan reset active_cnt", 32'(ac1), 32'd0);
    chk("midscan reset overrun", 32'(ovr1), 32'd0);
    chk("midscan reset busy settle2", 32'(busy2), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    nv = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      if (sv1 || sv2) nv++;
    end
    chk("midscan no valid", 32'(nv), 32'd0);
    run_sample(1'b0);
    chk("post reset latency", 32'(r_lat1), 32'd130);
    chk("post reset updates", 32'(r_n1), 32'd0);
    chk("post reset sample_out", r_out1, 32'd0);

`ifdef VOICE_LIMIT_EN
    do_write(7'd1, 7'd10);
    chk("cap key1 ld_vel", 32'(r_ldv3), 32'd1);
    do_write(7'd2, 7'd10);
    chk("cap key2 ld_vel", 32'(r_ldv3), 32'd1);
    do_write(7'd3, 7'd10);
    chk("cap key3 ld_vel", 32'(r_ldv3), 32'd0);
    chk("cap active_cnt", 32'(ac3), 32'd2);
    do_write(7'd1, 7'd20);
    chk("cap retrigger ld_vel", 32'(r_ldv3), 32'd1);
    chk("cap retrigger active_cnt", 32'(ac3), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
